// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FP request arbiter and its arbiter
// sub-block.
//   fp_op_e      : FPU operation encoding (add/sub/mul/div)
//   arb_state_e  : arbiter FSM states
//   FP_QNAN      : result returned on a timed-out operation
//   idx_width()  : width of an index into an n-entry vector (at least 1 bit)
// ---------------------------------------------------------------------------
package fpu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } fp_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam logic [31:0] FP_QNAN = 32'h7FC00000;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: grants the first set request at or
// after the pointer, wrapping from NREQ-1 back to 0.
// Ports:
//   req         in  NREQ  request vector
//   ptr         in  IW    highest-priority requester index (must be < NREQ)
//   grant       out NREQ  one-hot grant (zero when no request)
//   grant_idx   out IW    index of the granted requester
//   grant_valid out 1     any request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import fpu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_valid
);

   // cand_idx[k] is the requester examined at priority rank k (rank 0 = ptr).
   logic [IW-1:0]   cand_idx [NREQ];
   logic [NREQ-1:0] cand_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [IW:0] sum_w;
         // ptr < NREQ, so a single conditional subtract performs the wrap.
         assign sum_w        = {1'b0, ptr} + (IW+1)'(gi);
         assign cand_idx[gi] = (sum_w >= (IW+1)'(NREQ)) ? IW'(sum_w - (IW+1)'(NREQ))
                                                       : sum_w[IW-1:0];
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   assign grant_valid = |cand_hit;

   // Walk ranks from lowest priority to highest so the last hit written wins.
   always_comb begin
      grant_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            grant_idx = cand_idx[i];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_req_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_req_arbiter
// Shares one multi-cycle FP unit among NREQ requesters. Requests are granted
// round-robin, one operation is in flight at a time, and the result (or a
// quiet-NaN on timeout) is returned to the owner with a one-cycle strobe.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   req_valid  [NREQ]      request valid per requester
//   req_ready  [NREQ]      combinational accept, one-hot or zero
//   req_op     [NREQ*2]    op per requester (0 add,1 sub,2 mul,3 div)
//   req_a/b    [NREQ*32]   operands per requester
//   rsp_valid  [NREQ]      one-cycle response strobe to the owner
//   rsp_result [32]        result, held after the strobe
//   rsp_err    [1]         1 = timeout abort (result is quiet NaN)
//   fpu_start  [1]         one-cycle start pulse
//   fpu_op/a/b             operation, held until the next grant
//   fpu_done   [1]         completion strobe, only honoured while waiting
//   fpu_result [32]        FPU result, sampled with fpu_done
//   busy       [1]         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module fpu_req_arbiter
   import fpu_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*2-1:0]  req_op,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [31:0]        rsp_result,
   output logic               rsp_err,
   output logic               fpu_start,
   output logic [1:0]         fpu_op,
   output logic [31:0]        fpu_a,
   output logic [31:0]        fpu_b,
   input  logic               fpu_done,
   input  logic [31:0]        fpu_result,
   output logic               busy
);

   localparam int IW = idx_width(NREQ);
   localparam int TW = $clog2(TIMEOUT);

   arb_state_e       state_reg;
   logic [IW-1:0]    ptr_reg;
   logic [IW-1:0]    owner_reg;
   logic [TW-1:0]    timer_reg;
   logic             fpu_start_reg;
   fp_op_e           fpu_op_reg;
   logic [31:0]      fpu_a_reg;
   logic [31:0]      fpu_b_reg;
   logic [NREQ-1:0]  rsp_valid_reg;
   logic [31:0]      rsp_result_reg;
   logic             rsp_err_reg;

   logic [1:0]       op_arr [NREQ];
   logic [31:0]      a_arr  [NREQ];
   logic [31:0]      b_arr  [NREQ];

   logic [NREQ-1:0]  arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_valid;
   logic             grant_ok;
   logic [IW-1:0]    ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi] = req_op[gi*2 +: 2];
         assign a_arr[gi]  = req_a[gi*32 +: 32];
         assign b_arr[gi]  = req_b[gi*32 +: 32];
      end
   endgenerate

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req         (req_valid),
      .ptr         (ptr_reg),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // A grant is only offered while idle; the rst term keeps req_ready low on
   // the reset edge, where the latch below would be discarded anyway.
   assign grant_ok  = (state_reg == ST_IDLE) && !rst;
   assign req_ready = arb_grant & {NREQ{grant_ok}};

   assign ptr_next = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         ptr_reg        <= '0;
         owner_reg      <= '0;
         timer_reg      <= '0;
         fpu_start_reg  <= 1'b0;
         fpu_op_reg     <= OP_ADD;
         fpu_a_reg      <= '0;
         fpu_b_reg      <= '0;
         rsp_valid_reg  <= '0;
         rsp_result_reg <= '0;
         rsp_err_reg    <= 1'b0;
      end else begin
         fpu_start_reg <= 1'b0;
         rsp_valid_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (arb_valid) begin
                  owner_reg     <= arb_idx;
                  fpu_op_reg    <= fp_op_e'(op_arr[arb_idx]);
                  fpu_a_reg     <= a_arr[arb_idx];
                  fpu_b_reg     <= b_arr[arb_idx];
                  fpu_start_reg <= 1'b1;
                  state_reg     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Timer counts cycles since the start pulse; the start cycle
               // itself is cycle 0, so the first wait cycle sees 1.
               timer_reg <= TW'(1);
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // done takes priority over an expiring timer in the same cycle
               if (fpu_done) begin
                  rsp_result_reg           <= fpu_result;
                  rsp_err_reg              <= 1'b0;
                  rsp_valid_reg[owner_reg] <= 1'b1;
                  state_reg                <= ST_RESP;
               end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                  rsp_result_reg           <= FP_QNAN;
                  rsp_err_reg              <= 1'b1;
                  rsp_valid_reg[owner_reg] <= 1'b1;
                  state_reg                <= ST_RESP;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            ST_RESP: begin
               ptr_reg   <= ptr_next;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_err    = rsp_err_reg;
   assign fpu_start  = fpu_start_reg;
   assign fpu_op     = fpu_op_reg;
   assign fpu_a      = fpu_a_reg;
   assign fpu_b      = fpu_b_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_req_arbiter
// Drives queued requests into the arbiter, models the FPU (fixed latency,
// random latency, never-done, stray done pulses) and compares every DUT output
// each cycle against a transaction-timeline model. Directed scenarios also pin
// grant order, result, error flag and grant-to-response delay to literals.
// FPU latency L = idle cycles between the start cycle and the done cycle.
// ---------------------------------------------------------------------------
module tb_fpu_req_arbiter;

   localparam int N  = 3;
   localparam int TO = 64;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*2-1:0]    req_op;
   logic [N*32-1:0]   req_a;
   logic [N*32-1:0]   req_b;
   logic [N-1:0]      rsp_valid;
   logic [31:0]       rsp_result;
   logic              rsp_err;
   logic              fpu_start;
   logic [1:0]        fpu_op;
   logic [31:0]       fpu_a;
   logic [31:0]       fpu_b;
   logic              fpu_done;
   logic [31:0]       fpu_result;
   logic              busy;

   fpu_req_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .fpu_start  (fpu_start),
      .fpu_op     (fpu_op),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_done   (fpu_done),
      .fpu_result (fpu_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct packed {
      int          owner;
      logic [31:0] res;
      logic        err;
      int          delay;
   } lit_rsp_t;

   // written only by the main process
   req_t      rq [N][$];
   int        lit_grant_q [$];
   lit_rsp_t  lit_rsp_q [$];
   int        fpu_mode;     // 0 random, 1 fixed latency, 2 never done
   int        fix_lat;
   bit        end_req;
   // written only by the driver / monitor processes
   int        rd_idx [N];
   int        lit_gi;
   int        lit_ri;
   bit        end_done;
   int        checks;
   int        failures;

   function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      if (op == 2'd0 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
      if (op == 2'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (op == 2'd0 && a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000;
      return {op, a[29:0] ^ {b[14:0], b[29:15]}};
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int first_set(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (v[k]) return k;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%08h required=%08h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- requester driver ----------------
   initial begin
      logic [N-1:0] hs;
      req_t e;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      for (int i = 0; i < N; i++) rd_idx[i] = 0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && rd_idx[i] < rq[i].size()) begin
               e = rq[i][rd_idx[i]];
               rd_idx[i] = rd_idx[i] + 1;
               req_valid[i]        = 1'b1;
               req_op[i*2 +: 2]    = e.op;
               req_a[i*32 +: 32]   = e.a;
               req_b[i*32 +: 32]   = e.b;
            end
         end
      end
   end

   // ---------------- FPU model ----------------
   initial begin
      bit          pend;
      int          done_cyc;
      int          lat;
      logic [31:0] pres;
      pend = 0; done_cyc = 0; pres = '0;
      fpu_done = 1'b0; fpu_result = '0;
      forever begin
         @(posedge clk);
         #1;
         fpu_done = 1'b0;
         if (pend && cyc == done_cyc) begin
            fpu_done   = 1'b1;
            fpu_result = pres;
            pend       = 0;
         end else if (fpu_mode == 0 && !pend && $urandom_range(0, 7) == 0) begin
            fpu_done   = 1'b1;          // stray pulse with no operation outstanding
            fpu_result = $urandom;
         end
         if (fpu_start) begin
            lat      = (fpu_mode == 1) ? fix_lat : int'($urandom_range(0, 8));
            pend     = !(fpu_mode == 2 || (fpu_mode == 0 && $urandom_range(0, 11) == 0));
            done_cyc = cyc + lat + 1;
            pres     = fpu_fn(fpu_op, fpu_a, fpu_b);
         end
      end
   end

   // ---------------- reference model + compare ----------------
   initial begin
      bit          model_ok, m_act, m_err;
      int          m_g, m_own, m_resp_at, m_ptr, pk, gid, rid, grant_cyc;
      logic [1:0]  m_op;
      logic [31:0] m_a, m_b, m_res, m_last;
      logic [N-1:0] e_ready, e_rsp;
      lit_rsp_t    lr;
      model_ok = 0; m_act = 0; m_err = 0; m_g = 0; m_own = 0; m_resp_at = -1; m_ptr = 0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_last = '0; grant_cyc = 0;
      checks = 0; failures = 0; lit_gi = 0; lit_ri = 0; end_done = 0;
      forever begin
         @(negedge clk);
         pk = pick(req_valid, m_ptr);
         if (model_ok) begin
            e_ready = (!m_act && !rst && pk >= 0) ? N'(1 << pk) : '0;
            e_rsp   = (m_act && cyc == m_resp_at) ? N'(1 << m_own) : '0;
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("fpu_start", 32'(fpu_start), 32'(m_act && cyc == m_g + 1));
            chk("busy", 32'(busy), 32'(m_act));
            chk("fpu_op", 32'(fpu_op), 32'(m_op));
            chk("fpu_a", fpu_a, m_a);
            chk("fpu_b", fpu_b, m_b);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("rsp_result", rsp_result, (e_rsp != '0) ? m_res : m_last);
            if (e_rsp != '0) chk("rsp_err", 32'(rsp_err), 32'(m_err));

            if (!rst && req_ready != '0) begin
               gid = first_set(req_ready);
               grant_cyc = cyc;
               if (lit_gi < lit_grant_q.size()) begin
                  chk("lit_grant_owner", gid, lit_grant_q[lit_gi]);
                  lit_gi++;
               end
            end
            if (rsp_valid != '0) begin
               rid = first_set(rsp_valid);
               $display("txn cyc=%0d owner=%0d result=%08h err=%0b delay=%0d",
                        cyc, rid, rsp_result, rsp_err, cyc - grant_cyc);
               if (lit_ri < lit_rsp_q.size()) begin
                  lr = lit_rsp_q[lit_ri];
                  chk("lit_rsp_owner", rid, lr.owner);
                  chk("lit_rsp_result", rsp_result, lr.res);
                  chk("lit_rsp_err", 32'(rsp_err), 32'(lr.err));
                  chk("lit_rsp_delay", cyc - grant_cyc, lr.delay);
                  lit_ri++;
               end
            end
         end

         if (rst) begin
            m_act = 0; m_ptr = 0; m_op = '0; m_a = '0; m_b = '0; m_last = '0;
            model_ok = 1;
         end else if (!m_act) begin
            if (pk >= 0) begin
               m_act = 1; m_g = cyc; m_own = pk; m_resp_at = -1;
               m_op = req_op[pk*2 +: 2]; m_a = req_a[pk*32 +: 32]; m_b = req_b[pk*32 +: 32];
            end
         end else if (cyc == m_resp_at) begin
            m_ptr = (m_own + 1) % N; m_act = 0; m_last = m_res;
         end else if (cyc >= m_g + 2 && m_resp_at < 0) begin
            if (fpu_done) begin
               m_resp_at = cyc + 1; m_res = fpu_result; m_err = 0;
            end else if (cyc == m_g + TO) begin
               m_resp_at = cyc + 1; m_res = 32'h7FC00000; m_err = 1;
            end
         end

         if (end_req && !end_done) begin
            chk("lit_grants_seen", lit_gi, lit_grant_q.size());
            chk("lit_rsps_seen", lit_ri, lit_rsp_q.size());
            end_done = 1;
         end
      end
   end

   // ---------------- main sequence ----------------
   task automatic wait_lit(input int budget);
      int b = 0;
      while ((lit_gi < lit_grant_q.size() || lit_ri < lit_rsp_q.size()) && b < budget) begin
         @(posedge clk);
         b++;
      end
      if (b >= budget) begin
         $display("FAIL wait_lit timeout grants=%0d/%0d rsps=%0d/%0d",
                  lit_gi, lit_grant_q.size(), lit_ri, lit_rsp_q.size());
         $fatal(1, "bench stalled");
      end
      repeat (2) @(posedge clk);
   endtask

   function automatic req_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_t r;
      r.op = op; r.a = a; r.b = b;
      return r;
   endfunction

   function automatic lit_rsp_t lrsp(input int o, input logic [31:0] r, input logic e, input int d);
      lit_rsp_t x;
      x.owner = o; x.res = r; x.err = e; x.delay = d;
      return x;
   endfunction

   initial begin
      int b, n, who;
      rst = 1'b1; fpu_mode = 1; fix_lat = 3; end_req = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // single add, latency 3
      lit_grant_q.push_back(0);
      lit_rsp_q.push_back(lrsp(0, 32'h40000000, 1'b0, 6));
      rq[0].push_back(mk(2'd0, 32'h3F800000, 32'h3F800000));
      wait_lit(200);

      // sub from requester 1
      lit_grant_q.push_back(1);
      lit_rsp_q.push_back(lrsp(1, 32'h40000000, 1'b0, 6));
      rq[1].push_back(mk(2'd1, 32'h40400000, 32'h3F800000));
      wait_lit(200);

      // contention between 0 and 1, latency 2
      fix_lat = 2;
      for (int k = 0; k < 2; k++) begin
         rq[0].push_back(mk(2'd0, 32'h3F800000, 32'h3F800000));
         rq[1].push_back(mk(2'd0, 32'h40000000, 32'h40400000));
         lit_grant_q.push_back(0);
         lit_grant_q.push_back(1);
         lit_rsp_q.push_back(lrsp(0, 32'h40000000, 1'b0, 5));
         lit_rsp_q.push_back(lrsp(1, 32'h40A00000, 1'b0, 5));
      end
      wait_lit(400);

      // timeout, then a normal op
      fpu_mode = 2;
      lit_grant_q.push_back(2);
      lit_rsp_q.push_back(lrsp(2, 32'h7FC00000, 1'b1, 65));
      rq[2].push_back(mk(2'd3, 32'h41200000, 32'h40000000));
      wait_lit(300);
      fpu_mode = 1; fix_lat = 0;
      lit_grant_q.push_back(0);
      lit_rsp_q.push_back(lrsp(0, 32'h40000000, 1'b0, 3));
      rq[0].push_back(mk(2'd0, 32'h3F800000, 32'h3F800000));
      wait_lit(200);

      // done arrives on the last cycle before timeout
      fix_lat = 62;
      lit_grant_q.push_back(1);
      lit_rsp_q.push_back(lrsp(1, 32'h40A00000, 1'b0, 65));
      rq[1].push_back(mk(2'd0, 32'h40000000, 32'h40400000));
      wait_lit(300);

      // reset in WAIT, late done after release must be ignored
      fix_lat = 20;
      lit_grant_q.push_back(2);
      rq[2].push_back(mk(2'd2, 32'h40400000, 32'h40000000));
      b = 0;
      while (lit_gi < lit_grant_q.size() && b < 100) begin @(posedge clk); b++; end
      if (b >= 100) begin
         $display("FAIL reset_test_grant timeout");
         $fatal(1, "bench stalled");
      end
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (30) @(posedge clk);
      fix_lat = 1;
      rq[2].push_back(mk(2'd0, 32'h40000000, 32'h40400000));
      rq[1].push_back(mk(2'd1, 32'h40400000, 32'h3F800000));
      rq[0].push_back(mk(2'd0, 32'h3F800000, 32'h3F800000));
      lit_grant_q.push_back(0); lit_grant_q.push_back(1); lit_grant_q.push_back(2);
      lit_rsp_q.push_back(lrsp(0, 32'h40000000, 1'b0, 4));
      lit_rsp_q.push_back(lrsp(1, 32'h40000000, 1'b0, 4));
      lit_rsp_q.push_back(lrsp(2, 32'h40A00000, 1'b0, 4));
      wait_lit(300);

      // randomized traffic with random latency, timeouts and stray done pulses
      fpu_mode = 0;
      for (int burst = 0; burst < 10; burst++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            who = $urandom_range(0, N - 1);
            rq[who].push_back(mk(2'($urandom_range(0, 3)), $urandom, $urandom));
         end
         repeat ($urandom_range(0, 40)) @(posedge clk);
      end
      b = 0;
      while (b < 20000) begin
         @(posedge clk);
         b++;
         if (rd_idx[0] == rq[0].size() && rd_idx[1] == rq[1].size() &&
             rd_idx[2] == rq[2].size() && req_valid == '0 && !busy) break;
      end
      if (b >= 20000) begin
         $display("FAIL random_drain timeout busy=%0b valid=%b", busy, req_valid);
         $fatal(1, "bench stalled");
      end
      repeat (4) @(posedge clk);

      end_req = 1;
      b = 0;
      while (!end_done && b < 10) begin @(posedge clk); b++; end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
